router_pkt_tx: RTL and testbench

Packet source for the 1x3 router input port. It accepts a packet request (destination address and length), buffers the full payload, and then drives the router's `packet_valid`/`data` input with the header, payload and parity bytes. It honours the router's `busy` back-pressure and sits between a test or host agent and the router top's `datain`/`packet_valid`/`busy` pins.

---
 rtl/router_pkt_tx.sv | 128 ++++++++++++
 tb/tb_router_pkt_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port.
// Buffers a full payload for a request, then sends header, payload and parity
// to the router while honouring its busy back-pressure.
module router_pkt_tx #(
    parameter int IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    output logic       req_ready,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    output logic       packet_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       req_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_PARITY  = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    logic [2:0]    state;
    logic [7:0]    header;
    logic [7:0]    parity;
    logic [5:0]    wcnt;
    logic [5:0]    idx;
    logic [GW-1:0] gcnt;
    logic          tx_done_r;
    logic          req_err_r;
    logic [7:0]    mem [0:63];

    // Payload length lives in the upper six bits of the latched header.
    logic [5:0] len_m1;
    assign len_m1 = header[7:2] - 6'd1;

    // Main sequencer: request intake, payload load, byte transmit, idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            header    <= '0;
            parity    <= '0;
            wcnt      <= '0;
            idx       <= '0;
            gcnt      <= '0;
            tx_done_r <= 1'b0;
            req_err_r <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            req_err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_addr == 2'd3 || req_len == 6'd0) begin
                            req_err_r <= 1'b1;
                        end else begin
                            header <= {req_len, req_addr};
                            parity <= {req_len, req_addr};
                            wcnt   <= '0;
                            state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (pl_valid) begin
                        parity <= parity ^ pl_data;
                        wcnt   <= wcnt + 6'd1;
                        if (wcnt == len_m1) state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        idx   <= '0;
                        state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        idx <= idx + 6'd1;
                        if (idx == len_m1) state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        tx_done_r <= 1'b1;
                        gcnt      <= GW'(IDLE_GAP - 1);
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gcnt == '0) state <= S_IDLE;
                    else            gcnt  <= gcnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Payload buffer write port; contents are don't-care across reset.
    always_ff @(posedge clk) begin
        if (!rst && state == S_LOAD && pl_valid) mem[wcnt] <= pl_data;
    end

    // Output decode from registered state only.
    always_comb begin
        req_ready    = (state == S_IDLE);
        pl_ready     = (state == S_LOAD);
        packet_valid = (state == S_HEADER) || (state == S_PAYLOAD);
        tx_done      = tx_done_r;
        req_err      = req_err_r;
        case (state)
            S_HEADER:  data_out = header;
            S_PAYLOAD: data_out = mem[idx];
            S_PARITY:  data_out = parity;
            default:   data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: scoreboard of expected router bytes
// popped by a negedge monitor, plus per-scenario tasks with inline checks.
`timescale 1ns/1ps
module tb_router_pkt_tx;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_ready;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       packet_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       req_err;

    router_pkt_tx #(.IDLE_GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .busy(busy), .packet_valid(packet_valid), .data_out(data_out),
        .tx_done(tx_done), .req_err(req_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         is_par;
        int         hold;
    } exp_t;

    exp_t       sb[$];
    int         checks  = 0;
    int         passed  = 0;
    int         pres    = 0;
    int         txstage = 0;
    logic [7:0] pl_buf [0:63];

    // Monitor: compares each transferred byte against the scoreboard head,
    // including how many cycles it was presented and the tx_done pulse.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (txstage == 1) begin
                checks++;
                if (tx_done !== 1'b1) $display("FAIL tx_done_pulse got %b want 1", tx_done);
                else passed++;
                txstage = 2;
            end else if (txstage == 2) begin
                checks++;
                if (tx_done !== 1'b0) $display("FAIL tx_done_width got %b want 0", tx_done);
                else passed++;
                txstage = 0;
            end
            if (sb.size() > 0 && (sb[0].is_par || packet_valid === 1'b1)) begin
                pres++;
                if (busy === 1'b0) begin
                    checks++;
                    if (data_out !== sb[0].b || packet_valid !== (sb[0].is_par ? 1'b0 : 1'b1))
                        $display("FAIL byte got data=%02h pv=%b want data=%02h pv=%b",
                                 data_out, packet_valid, sb[0].b, !sb[0].is_par);
                    else passed++;
                    checks++;
                    if (pres !== sb[0].hold)
                        $display("FAIL hold byte=%02h got %0d cycles want %0d", sb[0].b, pres, sb[0].hold);
                    else passed++;
                    if (sb[0].is_par) txstage = 1;
                    void'(sb.pop_front());
                    pres = 0;
                end
            end else if (sb.size() == 0 && packet_valid === 1'b1) begin
                checks++;
                $display("FAIL unexpected_byte got data=%02h pv=1 want pv=0", data_out);
            end
        end
    end

    // Expected header, payload (from pl_buf) and parity for one packet.
    task automatic push_pkt(input int len, input logic [7:0] hdr, input logic [7:0] par,
                            input int hh, input int hidx, input int hval);
        exp_t e;
        e.b = hdr; e.is_par = 1'b0; e.hold = hh;
        sb.push_back(e);
        for (int i = 0; i < len; i++) begin
            e.b = pl_buf[i]; e.is_par = 1'b0; e.hold = (i == hidx) ? hval : 1;
            sb.push_back(e);
        end
        e.b = par; e.is_par = 1'b1; e.hold = 1;
        sb.push_back(e);
    endtask

    task automatic send_req(input logic [1:0] a, input logic [5:0] l, input bit keep);
        int t;
        t = 0;
        req_addr = a; req_len = l; req_valid = 1'b1;
        while (req_ready !== 1'b1 && t < 500) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 500) begin checks++; $display("FAIL req_accept_timeout got ready=%b want 1", req_ready); end
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic feed(input int n);
        int i;
        int t;
        i = 0; t = 0;
        while (i < n && t < 2000) begin
            if (pl_ready === 1'b1) begin
                pl_valid = 1'b1; pl_data = pl_buf[i]; i++;
            end else pl_valid = 1'b0;
            @(posedge clk); #1; t++;
        end
        pl_valid = 1'b0;
        if (t >= 2000) begin checks++; $display("FAIL feed_timeout got %0d bytes want %0d", i, n); end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || txstage != 0 || req_ready !== 1'b1) && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 1000) begin
            checks++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        pl_valid = 1'b0; pl_data = '0; busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
        checks++;
        if ({packet_valid, data_out} !== 9'h000)
            $display("FAIL reset_tx got pv=%b data=%02h want pv=0 data=00", packet_valid, data_out);
        else passed++;
        checks++;
        if ({pl_ready, tx_done, req_err} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {pl_ready, tx_done, req_err});
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
        push_pkt(3, 8'h0D, 8'h0D, 1, -1, 1);
        send_req(2'd1, 6'd3, 1'b0);
        feed(3);
        drain();
    endtask

    task automatic test_busy_stall();
        int t;
        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
        push_pkt(3, 8'h0D, 8'h0D, 1, 1, 4);
        send_req(2'd1, 6'd3, 1'b0);
        feed(3);
        t = 0;
        while (sb.size() != 3 && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin checks++; $display("FAIL busy_sync_timeout got %0d want 3", sb.size()); end
        busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        busy = 1'b0;
        drain();
    endtask

    task automatic test_illegal();
        logic [1:0] a_tab [0:1];
        logic [5:0] l_tab [0:1];
        a_tab[0] = 2'd3; l_tab[0] = 6'd5;
        a_tab[1] = 2'd0; l_tab[1] = 6'd0;
        for (int k = 0; k < 2; k++) begin
            req_addr = a_tab[k]; req_len = l_tab[k]; req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({req_err, pl_ready, req_ready} !== 3'b101)
                $display("FAIL illegal%0d_resp got err/plr/rdy=%b want 101", k, {req_err, pl_ready, req_ready});
            else passed++;
            @(negedge clk);
            checks++;
            if ({req_err, pl_ready, req_ready} !== 3'b001)
                $display("FAIL illegal%0d_after got err/plr/rdy=%b want 001", k, {req_err, pl_ready, req_ready});
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 63; i++) pl_buf[i] = 8'(i);
        push_pkt(63, 8'hFE, 8'hC1, 2, -1, 1);
        send_req(2'd2, 6'd63, 1'b0);
        feed(63);
        // Header has just appeared: raise busy in its first cycle.
        busy = 1'b1;
        @(posedge clk); #1;
        busy = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        int t;
        int k;
        pl_buf[0] = 8'hAA; pl_buf[1] = 8'hBB; pl_buf[2] = 8'hCC;
        push_pkt(3, 8'h0C, 8'hD1, 1, -1, 1);
        send_req(2'd0, 6'd3, 1'b1);
        pl_valid = 1'b1; pl_data = 8'hAA; @(posedge clk); #1;
        pl_valid = 1'b0;                  @(posedge clk); #1;
        pl_valid = 1'b1; pl_data = 8'hBB; @(posedge clk); #1;
        pl_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({pl_ready, packet_valid} !== 2'b10)
            $display("FAIL load_gap_hold got plr/pv=%b want 10", {pl_ready, packet_valid});
        else passed++;
        @(posedge clk); #1;
        pl_valid = 1'b1; pl_data = 8'hCC; @(posedge clk); #1;
        pl_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({pl_ready, packet_valid} !== 2'b01)
            $display("FAIL load_done_header got plr/pv=%b want 01", {pl_ready, packet_valid});
        else passed++;
        t = 0;
        while (tx_done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin checks++; $display("FAIL b2b_tx_done_timeout got 0 want 1"); end
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (k !== GAP) $display("FAIL b2b_gap got %0d cycles want %0d", k, GAP); else passed++;
        // req_valid is still high, so the pending request is taken on this edge.
        push_pkt(3, 8'h0C, 8'hD1, 1, -1, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (pl_ready !== 1'b1) $display("FAIL b2b_second_accept got %b want 1", pl_ready); else passed++;
        feed(3);
        drain();
    endtask

    task automatic test_reset_mid();
        int t;
        int txc;
        pl_buf[0] = 8'hA1; pl_buf[1] = 8'hB2; pl_buf[2] = 8'hC3; pl_buf[3] = 8'hD4;
        push_pkt(4, 8'h10, 8'h14, 1, -1, 1);
        send_req(2'd0, 6'd4, 1'b0);
        feed(4);
        t = 0;
        while (sb.size() != 4 && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin checks++; $display("FAIL rst_sync_timeout got %0d want 4", sb.size()); end
        rst = 1'b1; sb.delete(); pres = 0; txstage = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({packet_valid, data_out, req_ready, pl_ready} !== 11'b0_00000000_1_0)
            $display("FAIL rst_mid_outputs got pv=%b data=%02h rdy=%b plr=%b want 0 00 1 0",
                     packet_valid, data_out, req_ready, pl_ready);
        else passed++;
        txc = 0;
        repeat (8) begin @(negedge clk); if (tx_done === 1'b1) txc++; end
        checks++;
        if (txc !== 0) $display("FAIL rst_mid_no_tx_done got %0d want 0", txc); else passed++;
        @(posedge clk); #1;
        pl_buf[0] = 8'h55; pl_buf[1] = 8'hAA;
        push_pkt(2, 8'h0A, 8'hF5, 1, -1, 1);
        send_req(2'd2, 6'd2, 1'b0);
        feed(2);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_illegal();
        test_max_len();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
